// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the core/DMA memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  typedef logic owner_t;
  localparam owner_t OWN_CORE = 1'b0;
  localparam owner_t OWN_DMA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the unified RAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req, core_we, core_gnt, core_rvalid;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic              dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              err;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output err
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port RAM: core has priority, DMA gets
// forced priority after MAX_WAIT consecutive losses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] dma_wait, wait_d;
  logic              dma_win, misaligned;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_CORE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dma_wait <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dma_wait <= wait_d;
    end
  end

  assign misaligned = (addr_q[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = dma_wait;
    dma_win = 1'b0;

    bus.core_gnt    = 1'b0;
    bus.core_rvalid = 1'b0;
    bus.core_rdata  = '0;
    bus.dma_gnt     = 1'b0;
    bus.dma_rvalid  = 1'b0;
    bus.dma_rdata   = '0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.err         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.core_req || bus.dma_req) begin
          dma_win = bus.dma_req && (!bus.core_req || dma_wait == WAIT_MAX);
          state_d = ACCESS;
          if (dma_win) begin
            owner_d = OWN_DMA;
            we_d    = bus.dma_we;
            addr_d  = bus.dma_addr;
            wdata_d = bus.dma_wdata;
            wait_d  = '0;
          end else begin
            owner_d = OWN_CORE;
            we_d    = bus.core_we;
            addr_d  = bus.core_addr;
            wdata_d = bus.core_wdata;
            if (bus.dma_req && dma_wait != WAIT_MAX)
              wait_d = dma_wait + 1'b1;
          end
        end
      end
      ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q && !misaligned;
        bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus.mem_wdata = wdata_q;
        bus.err       = misaligned;
        bus.core_gnt  = (owner_q == OWN_CORE);
        bus.dma_gnt   = (owner_q == OWN_DMA);
        state_d       = we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        if (owner_q == OWN_DMA) begin
          bus.dma_rvalid = 1'b1;
          bus.dma_rdata  = bus.mem_rdata;
        end else begin
          bus.core_rvalid = 1'b1;
          bus.core_rdata  = bus.mem_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset is synchronous, so the in-flight state is still visible during the
    // reset cycle; gate every output so an abandoned access never reaches RAM.
    if (!reset) begin
      bus.core_gnt    = 1'b0;
      bus.core_rvalid = 1'b0;
      bus.core_rdata  = '0;
      bus.dma_gnt     = 1'b0;
      bus.dma_rvalid  = 1'b0;
      bus.dma_rdata   = '0;
      bus.mem_en      = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      bus.err         = 1'b0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 4, count of DMA losses before DMA gets forced priority.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 core_req / core_we  in  1 / 1  multicycle core access request; write enable.
REQ-007 core_addr / core_wdata  in  ADDR_W / DATA_W  core byte address; core write data.
REQ-008 core_gnt / core_rvalid  out  1 / 1  core access performed; core read data valid.
REQ-009 core_rdata  out  DATA_W  core read data.
REQ-010 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same widths, directions and meanings as the core port, for the loader/DMA requester.
REQ-011 mem_en / mem_we  out  1 / 1  unified RAM access strobe; RAM write enable.
REQ-012 mem_addr / mem_wdata  out  ADDR_W / DATA_W  RAM address; RAM write data.
REQ-013 mem_rdata  in  DATA_W  RAM read data, valid one cycle after a mem_en read.
REQ-014 err  out  1  one-cycle pulse when a misaligned access is granted.

Function
REQ-015 FSM states: IDLE, ACCESS, RDWAIT; one transaction in flight at a time.
REQ-016 IDLE with no request: stay in IDLE; all strobes low.
REQ-017 IDLE with at least one req: pick a winner; latch its we/addr/wdata and an owner ID; go to ACCESS.
REQ-018 Default priority: core wins over DMA.
REQ-019 Override: DMA wins when both request and dma_wait == MAX_WAIT.
REQ-020 dma_wait (saturating, width clog2(MAX_WAIT+1)): +1 each IDLE arbitration the DMA loses; cleared when DMA is granted; holds otherwise.
REQ-021 ACCESS lasts one cycle: mem_en=1; mem_addr/mem_wdata/mem_we from the latched values; owner's gnt=1.
REQ-022 From ACCESS: write goes to IDLE; read goes to RDWAIT.
REQ-023 RDWAIT lasts one cycle: owner's rvalid=1; owner's rdata=mem_rdata; then IDLE.
REQ-024 Latency: req sampled in IDLE at edge N gives gnt in cycle N+1; a read also gives rvalid in cycle N+2.
REQ-025 Requester holds req and operands stable until gnt, and drops req in the cycle after gnt unless it starts a new access.
REQ-026 Requests arriving in ACCESS/RDWAIT are ignored until IDLE.
REQ-027 Minimum occupancy: write = 2 cycles including the IDLE bubble; read = 3 cycles.
REQ-028 Misaligned access (addr[1:0] != 0): still granted and err pulses in ACCESS. Write: mem_we forced 0. Read: performed at addr with [1:0] cleared.
REQ-029 Non-owner gnt/rvalid stay 0; non-owner rdata is 0.
REQ-030 Both requests arrive in the same IDLE cycle: exactly one grant, per REQ-018/REQ-019; the loser is re-arbitrated at the next IDLE.

Reset
REQ-031 reset=0 at a clock edge: state goes to IDLE; dma_wait, latched values and owner clear to 0.
REQ-032 During and after reset, every output is 0 until a new grant.
REQ-033 Reset in ACCESS or RDWAIT abandons the transaction: no gnt or rvalid after reset, and no RAM write in the reset cycle.

Structure
REQ-034 Package mem_arb_pkg holds the state enum, owner ID constants (OWN_CORE=0, OWN_DMA=1) and the default widths.
REQ-035 Single module, no sub-module; the MEM instance connects directly to the mem_* port.

Verification
REQ-036 Core read only: core_req, addr 0x00000010, RAM[4]=0xDEADBEEF. Required: core_gnt in cycle+1; core_rvalid with 0xDEADBEEF in cycle+2; dma_* stay 0.
REQ-037 DMA write: addr 0x10010000, data 0x34. Required: mem_we=1 for one cycle; a later core read of the same address returns 0x00000034.
REQ-038 Both request continuously, MAX_WAIT=4. Required grant order core,core,core,core,DMA, then repeating; dma_wait returns to 0 after each DMA grant.
REQ-039 Core write to addr 0x00000006. Required: err pulses once; mem_we=0; RAM unchanged.
REQ-040 reset asserted during RDWAIT. Required: no rvalid; all outputs 0; the next core read completes normally.
REQ-041 Bench drives the real rv_mc core on the core port and a hex loader on the DMA port. Required: test_program.hex results match the expected register values, with CPI measured against the 0-bubble baseline.
